// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
package dff_arb_pkg;

  // Arbiter ownership state: nobody holds the register, or one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // $clog2 that never returns 0, so derived vector widths stay legal for tiny parameters.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: finds the first asserted request at or after ptr, wrapping to 0.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = safe_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // Walk the requesters in priority order starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that lets one requester at a time load the shared register bank.
// Ownership ends when the owner drops req or after MAX_HOLD cycles, then rotates.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  localparam int ID_W    = safe_clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           owner,
  output logic                      busy,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d
);

  localparam int HOLD_W = safe_clog2(MAX_HOLD + 1);

  arb_state_e          state;
  logic [ID_W-1:0]     ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ID_W-1:0]     next_owner;
  logic [ID_W-1:0]     search_ptr;
  logic                drop_grant;
  logic                found;
  logic [ID_W-1:0]     pick_idx;
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  // Unpack the flat write-data bus so the owner can index it directly.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Ownership ends when the owner lets go or its hold budget is used up; the next search
  // starts just past the owner so a lone requester can still wrap back to itself.
  always_comb begin
    next_owner = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
    drop_grant = (state == GRANT) &&
                 (!req[owner] || (hold_cnt == HOLD_W'(MAX_HOLD - 1)));
    search_ptr = drop_grant ? next_owner : ptr;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (search_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // Ownership FSM with registered grant, owner and busy; handoff has no idle bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            gnt      <= NUM_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (drop_grant) begin
            ptr      <= next_owner;
            hold_cnt <= '0;
            if (found) begin
              gnt   <= NUM_REQ'(1) << pick_idx;
              owner <= pick_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Load strobe follows the owner's live request so a dropped req stops loading immediately.
  always_comb begin
    reg_en = busy & req[owner];
    reg_d  = reg_en ? wdata_arr[owner] : '0;
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        reg_en;
  logic [7:0]  reg_d;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic       en;
    logic [7:0] d;
    logic [1:0] owner;
  } exp_t;

  exp_t sbq[$];
  int   numChecks = 0;
  int   numFails  = 0;
  logic [7:0] wtab [4];

  dff_bank_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .MAX_HOLD (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .reg_en (reg_en),
    .reg_d  (reg_d)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] onehotIdx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    numChecks++;
    if (act !== expv) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic applyStimulus(input logic rstV, input logic [3:0] reqV,
                               input logic [3:0] expGnt, input logic expEn);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rstV;
    req   = reqV;
    e.gnt   = expGnt;
    e.busy  = |expGnt;
    e.en    = expEn;
    e.owner = onehotIdx(expGnt);
    e.d     = expEn ? wtab[onehotIdx(expGnt)] : 8'h00;
    sbq.push_back(e);
  endtask

  // Monitor: pop one expectation per cycle and run the standing invariants.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checkOutput("gnt",    32'(gnt),    32'(e.gnt));
      checkOutput("busy",   32'(busy),   32'(e.busy));
      checkOutput("reg_en", 32'(reg_en), 32'(e.en));
      checkOutput("reg_d",  32'(reg_d),  32'(e.d));
      if (e.busy) checkOutput("owner", 32'(owner), 32'(e.owner));
    end
    checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (reg_en) checkOutput("reg_d_of_owner", 32'(reg_d), 32'(wtab[owner]));
  end

  initial begin
    wtab[0] = 8'h11;
    wtab[1] = 8'h22;
    wtab[2] = 8'hA5;
    wtab[3] = 8'h33;
    wdata = {wtab[3], wtab[2], wtab[1], wtab[0]};
    reset = 1'b0;
    req   = 4'b0000;

    $display("[TB] reset held with all requests asserted");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);

    $display("[TB] single requester 2 for two granted cycles");
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);

    $display("[TB] all requesters: rotation with four-cycle holds");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      logic [3:0] expG;
      expG = 4'b0001 << (g % 4);
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'b1111, expG, 1'b1);
    end

    $display("[TB] lone requester 1 re-granted past hold limit");
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b1);

    $display("[TB] owner drop hands over to pending requester 3");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1001, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1001, 4'b0001, 1'b1);
    applyStimulus(1'b1, 4'b1000, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b1);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b1);

    $display("[TB] async reset in the middle of a grant");
    applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0101, 4'b0001, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
